move_cmd_sched: RTL and testbench

//  Sequences every piece-move request into one command stream for the game FSM. Sources are the gravity tick (sys_event pulse from the fall-period generator) and debounced key pulses.

---
 rtl/tetris_pkg.sv | 45 ++++
 rtl/move_cmd_sched_prio_sel.sv | 23 ++
 rtl/move_cmd_sched.sv | 171 +++++++++++++++++
 tb/tb_move_cmd_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the move-command scheduler: command encoding, scheduler
// states, per-source pending-vector layout and a one-hot to command helper.
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_LEFT      = 3'd1,
        CMD_RIGHT     = 3'd2,
        CMD_ROTATE    = 3'd3,
        CMD_DOWN      = 3'd4,
        CMD_GRAVITY   = 3'd5,
        CMD_HARD_DROP = 3'd6
    } move_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_LOCKOUT
    } sched_state_t;

    localparam int NUM_SRC       = 6;
    localparam int SRC_LEFT      = 0;
    localparam int SRC_RIGHT     = 1;
    localparam int SRC_ROTATE    = 2;
    localparam int SRC_DOWN      = 3;
    localparam int SRC_GRAVITY   = 4;
    localparam int SRC_HARD_DROP = 5;

    // Key sources are everything except the gravity tick.
    localparam logic [NUM_SRC-1:0] GRAV_MASK = 6'b010000;
    localparam logic [NUM_SRC-1:0] KEY_MASK  = 6'b101111;

    function automatic move_cmd_t src_to_cmd(input logic [NUM_SRC-1:0] oh);
        move_cmd_t c;
        c = CMD_NONE;
        if (oh[SRC_LEFT])      c = CMD_LEFT;
        if (oh[SRC_RIGHT])     c = CMD_RIGHT;
        if (oh[SRC_ROTATE])    c = CMD_ROTATE;
        if (oh[SRC_DOWN])      c = CMD_DOWN;
        if (oh[SRC_GRAVITY])   c = CMD_GRAVITY;
        if (oh[SRC_HARD_DROP]) c = CMD_HARD_DROP;
        return c;
    endfunction

endpackage

// File: rtl/move_cmd_sched_prio_sel.sv
// Fixed-priority winner select over the pending vector; an aged gravity
// request jumps ahead of everything, including hard drop.
module prio_sel
    import tetris_pkg::*;
(
    input  logic [NUM_SRC-1:0] pending,
    input  logic               aged,
    output logic [NUM_SRC-1:0] grant
);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        if (aged && pending[SRC_GRAVITY])  grant[SRC_GRAVITY]   = 1'b1;
        else if (pending[SRC_HARD_DROP])   grant[SRC_HARD_DROP] = 1'b1;
        else if (pending[SRC_ROTATE])      grant[SRC_ROTATE]    = 1'b1;
        else if (pending[SRC_LEFT])        grant[SRC_LEFT]      = 1'b1;
        else if (pending[SRC_RIGHT])       grant[SRC_RIGHT]     = 1'b1;
        else if (pending[SRC_DOWN])        grant[SRC_DOWN]      = 1'b1;
        else if (pending[SRC_GRAVITY])     grant[SRC_GRAVITY]   = 1'b1;
    end

endmodule

// File: rtl/move_cmd_sched.sv
// Merges gravity ticks and key pulses into one valid/ready command stream.
// Optional MOVE_CMD_STATS_EN adds a saturating discarded-request counter.
module move_cmd_sched
    import tetris_pkg::*;
#(
    parameter int GRAV_AGE_MAX = 16,
    parameter int LOCKOUT_CYC  = 8
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      sys_event_i,
    input  logic      left_i,
    input  logic      right_i,
    input  logic      rotate_i,
    input  logic      down_i,
    input  logic      drop_i,
    input  logic      pause_i,
    input  logic      flush_i,
    output logic      cmd_valid_o,
    output move_cmd_t cmd_o,
    input  logic      cmd_ready_i
`ifdef MOVE_CMD_STATS_EN
    ,
    output logic [15:0] stat_coalesced_o
`endif
);

    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);

    sched_state_t        state_q, state_d;
    move_cmd_t           cmd_q, cmd_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NUM_SRC-1:0]  flags_q, flags_d;
    logic [7:0]          age_q, age_d;

    logic [NUM_SRC-1:0]  pulses, acc, sel_oh, grant_oh;
    logic                xfer, enter_lock, grant_en, aged;

    assign pulses = {drop_i, sys_event_i, down_i, rotate_i, right_i, left_i};
    assign aged   = (age_q >= 8'(GRAV_AGE_MAX));
    assign xfer   = (state_q == ST_OFFER) && cmd_ready_i;
    assign enter_lock = xfer && (cmd_q == CMD_HARD_DROP) && !flush_i;

    prio_sel u_prio_sel (
        .pending (flags_q),
        .aged    (aged),
        .grant   (sel_oh)
    );

    // Only flags registered before this edge compete; same-cycle arrivals wait.
    always_comb begin
        grant_en = 1'b0;
        if (!flush_i && !pause_i && (|flags_q)) begin
            grant_en = (state_q == ST_IDLE) ||
                       (xfer && (cmd_q != CMD_HARD_DROP));
        end
        grant_oh = grant_en ? sel_oh : '0;
    end

    always_comb begin
        acc = '0;
        if (!flush_i && !pause_i) begin
            acc = pulses;
            if ((state_q == ST_LOCKOUT) || enter_lock) acc = acc & GRAV_MASK;
            if (acc[SRC_LEFT] && acc[SRC_RIGHT]) begin
                acc[SRC_LEFT]  = 1'b0;
                acc[SRC_RIGHT] = 1'b0;
            end
        end
    end

    always_comb begin
        flags_d = flags_q & ~grant_oh;
        if (enter_lock)     flags_d = flags_d & GRAV_MASK;
        if (acc[SRC_LEFT])  flags_d[SRC_RIGHT] = 1'b0;
        if (acc[SRC_RIGHT]) flags_d[SRC_LEFT]  = 1'b0;
        flags_d = flags_d | acc;
        if (flush_i) flags_d = '0;

        age_d = age_q;
        if (flush_i || grant_oh[SRC_GRAVITY]) age_d = '0;
        else if (flags_q[SRC_GRAVITY] && !pause_i && (age_q != 8'hFF)) age_d = age_q + 8'd1;
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    state_d = ST_OFFER;
                    cmd_d   = src_to_cmd(grant_oh);
                end
            end
            ST_OFFER: begin
                if (xfer) begin
                    if (cmd_q == CMD_HARD_DROP) begin
                        state_d    = ST_LOCKOUT;
                        cmd_d      = CMD_NONE;
                        lock_cnt_d = LOCK_W'(LOCKOUT_CYC - 1);
                    end else if (grant_en) begin
                        cmd_d = src_to_cmd(grant_oh);
                    end else begin
                        state_d = ST_IDLE;
                        cmd_d   = CMD_NONE;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == '0) state_d = ST_IDLE;
                else                  lock_cnt_d = lock_cnt_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_NONE;
            end
        endcase
        if (flush_i) begin
            state_d    = ST_IDLE;
            cmd_d      = CMD_NONE;
            lock_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NONE;
            lock_cnt_q <= '0;
            flags_q    <= '0;
            age_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            lock_cnt_q <= lock_cnt_d;
            flags_q    <= flags_d;
            age_q      <= age_d;
        end
    end

    assign cmd_valid_o = (state_q == ST_OFFER);
    assign cmd_o       = cmd_q;

`ifdef MOVE_CMD_STATS_EN
    logic [15:0]        stat_q;
    logic [NUM_SRC-1:0] dropped, coalesced;
    logic               cancel;
    logic [3:0]         n_disc;
    logic [16:0]        stat_sum;

    // Flush discards are not counted; cancelling a pending opposite move is.
    always_comb begin
        dropped   = flush_i ? '0 : (pulses & ~acc);
        coalesced = acc & flags_q & ~grant_oh;
        cancel    = (acc[SRC_RIGHT] && flags_q[SRC_LEFT]  && !grant_oh[SRC_LEFT]) ||
                    (acc[SRC_LEFT]  && flags_q[SRC_RIGHT] && !grant_oh[SRC_RIGHT]);
        n_disc    = 4'($countones(dropped)) + 4'($countones(coalesced)) + {3'd0, cancel};
        stat_sum  = {1'b0, stat_q} + {13'd0, n_disc};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) stat_q <= '0;
        else          stat_q <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
    end

    assign stat_coalesced_o = stat_q;
`endif

endmodule

// File: tb/tb_move_cmd_sched.sv
// Directed bench for move_cmd_sched: a vector table for single-edge behaviour
// plus hand sequences for lockout, async reset and gravity aging.
module tb_move_cmd_sched;
    import tetris_pkg::*;

    logic      clk, rst_n;
    logic      sys_event, left, right, rotate, down, drop, pause, flush, ready;
    logic      cmd_valid;
    move_cmd_t cmd;
`ifdef MOVE_CMD_STATS_EN
    logic [15:0] stat;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [8:0] I_NONE  = 9'h000;
    localparam logic [8:0] I_SYS   = 9'h001;
    localparam logic [8:0] I_LEFT  = 9'h002;
    localparam logic [8:0] I_RIGHT = 9'h004;
    localparam logic [8:0] I_ROT   = 9'h008;
    localparam logic [8:0] I_DOWN  = 9'h010;
    localparam logic [8:0] I_DROP  = 9'h020;
    localparam logic [8:0] I_PAUSE = 9'h040;
    localparam logic [8:0] I_FLUSH = 9'h080;
    localparam logic [8:0] I_RDY   = 9'h100;

    typedef struct {
        logic [8:0] in;
        logic       ev;
        move_cmd_t  ec;
    } vec_t;

    vec_t vecs[$];

    move_cmd_sched #(.GRAV_AGE_MAX(16), .LOCKOUT_CYC(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .sys_event_i (sys_event),
        .left_i      (left),
        .right_i     (right),
        .rotate_i    (rotate),
        .down_i      (down),
        .drop_i      (drop),
        .pause_i     (pause),
        .flush_i     (flush),
        .cmd_valid_o (cmd_valid),
        .cmd_o       (cmd),
        .cmd_ready_i (ready)
`ifdef MOVE_CMD_STATS_EN
        ,
        .stat_coalesced_o (stat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] pack(input logic v, input move_cmd_t c);
        return {12'd0, v, c};
    endfunction

    task automatic chk_out(input string name, input logic ev, input move_cmd_t ec);
        check(name, pack(cmd_valid, cmd), pack(ev, ec));
    endtask

    task automatic drive(input logic [8:0] in);
        sys_event = in[0];
        left      = in[1];
        right     = in[2];
        rotate    = in[3];
        down      = in[4];
        drop      = in[5];
        pause     = in[6];
        flush     = in[7];
        ready     = in[8];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [8:0] in, input logic ev, input move_cmd_t ec);
        vec_t v;
        v.in = in;
        v.ev = ev;
        v.ec = ec;
        vecs.push_back(v);
    endtask

    initial begin
        // Single pulse, back-to-back, left/right clash and cancel, pause, flush.
        add(I_RDY,                   1'b0, CMD_NONE);
        add(I_DOWN | I_RDY,          1'b0, CMD_NONE);
        add(I_RDY,                   1'b1, CMD_DOWN);
        add(I_RDY,                   1'b0, CMD_NONE);
        add(I_ROT | I_SYS | I_RDY,   1'b0, CMD_NONE);
        add(I_RDY,                   1'b1, CMD_ROTATE);
        add(I_RDY,                   1'b1, CMD_GRAVITY);
        add(I_RDY,                   1'b0, CMD_NONE);
        add(I_LEFT | I_RIGHT | I_RDY, 1'b0, CMD_NONE);
        add(I_RDY,                   1'b0, CMD_NONE);
        add(I_ROT,                   1'b0, CMD_NONE);
        add(I_LEFT,                  1'b1, CMD_ROTATE);
        add(I_RIGHT,                 1'b1, CMD_ROTATE);
        add(I_RDY,                   1'b1, CMD_RIGHT);
        add(I_RDY,                   1'b0, CMD_NONE);
        add(I_DOWN | I_PAUSE | I_RDY, 1'b0, CMD_NONE);
        add(I_RDY,                   1'b0, CMD_NONE);
        add(I_LEFT,                  1'b0, CMD_NONE);
        add(I_PAUSE,                 1'b0, CMD_NONE);
        add(I_NONE,                  1'b1, CMD_LEFT);
        add(I_PAUSE | I_RDY,         1'b0, CMD_NONE);
        add(I_NONE,                  1'b0, CMD_NONE);
        add(I_DOWN,                  1'b0, CMD_NONE);
        add(I_NONE,                  1'b1, CMD_DOWN);
        add(I_FLUSH | I_LEFT | I_RDY, 1'b0, CMD_NONE);
        add(I_RDY,                   1'b0, CMD_NONE);
        add(I_ROT,                   1'b0, CMD_NONE);
        add(I_DOWN,                  1'b1, CMD_ROTATE);
        add(I_FLUSH,                 1'b0, CMD_NONE);
        add(I_RDY,                   1'b0, CMD_NONE);

        rst_n = 1'b0;
        drive(I_NONE);
        repeat (2) step();
        chk_out("reset", 1'b0, CMD_NONE);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec);
        end

        // Hard drop: key flags cleared, keys ignored for 8 cycles, gravity still pends.
        drive(I_DROP | I_RDY);
        step();
        chk_out("hd_pend", 1'b0, CMD_NONE);
        drive(I_DOWN | I_RDY);
        step();
        chk_out("hd_offer", 1'b1, CMD_HARD_DROP);
        drive(I_RDY);
        step();
        chk_out("hd_xfer", 1'b0, CMD_NONE);
        for (int k = 1; k <= 8; k++) begin
            drive((k == 3) ? (I_LEFT | I_SYS | I_RDY) : (I_LEFT | I_RDY));
            step();
            chk_out($sformatf("lock%0d", k), 1'b0, CMD_NONE);
        end
        drive(I_RDY);
        step();
        chk_out("lock_grav", 1'b1, CMD_GRAVITY);
        step();
        chk_out("lock_after", 1'b0, CMD_NONE);

        // Async reset between edges while a command is offered.
        drive(I_ROT);
        step();
        drive(I_NONE);
        step();
        chk_out("rst_pre", 1'b1, CMD_ROTATE);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, CMD_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        drive(I_RDY);
        step();
        chk_out("rst_post", 1'b0, CMD_NONE);

        // Gravity reaches age 16 exactly at the transfer edge -> beats DOWN.
        drive(I_LEFT);
        step();
        chk_out("age16_l", 1'b0, CMD_NONE);
        for (int k = 0; k < 17; k++) begin
            drive((k == 0) ? (I_DOWN | I_SYS) : I_DOWN);
            step();
            chk_out($sformatf("age16_hold%0d", k), 1'b1, CMD_LEFT);
        end
        drive(I_RDY);
        step();
        chk_out("age16_grav", 1'b1, CMD_GRAVITY);
        step();
        chk_out("age16_down", 1'b1, CMD_DOWN);
        step();
        chk_out("age16_idle", 1'b0, CMD_NONE);
`ifdef MOVE_CMD_STATS_EN
        check("stat16", stat, 16'd16);
`endif

        // Gravity only at age 15 -> normal priority, DOWN goes first.
        drive(I_LEFT);
        step();
        drive(I_DOWN | I_SYS);
        step();
        chk_out("age15_l", 1'b1, CMD_LEFT);
        drive(I_NONE);
        repeat (15) step();
        drive(I_RDY);
        step();
        chk_out("age15_down", 1'b1, CMD_DOWN);
        step();
        chk_out("age15_grav", 1'b1, CMD_GRAVITY);
        step();
        chk_out("age15_idle", 1'b0, CMD_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
